divq_stream_divider: RTL

//  Upstream feeder for the 2048x13 distributed quotient RAM of the SNTRUP757 datapath.

---
 rtl/divq_stream_divider.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/divq_stream_divider.sv
// divq_stream_divider
// Streams N source coefficients through a 13-step restoring divider by Q and
// writes each quotient to the quotient RAM at the coefficient's own index.
// One coefficient costs 15 cycles: FETCH, 13 x DIV, WRITE.
// Optional feature macro: DIVQ_REM_OUT_EN adds rem_we/rem_data, which export
// x mod Q alongside every quotient write.
module divq_stream_divider #(
    parameter int Q             = 4591,
    parameter int IN_WIDTH      = 26,
    parameter int RAM_WIDTH     = 13,
    parameter int RAM_ADDR_BITS = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS:0]   count,
    output logic [RAM_ADDR_BITS-1:0] src_addr,
    input  logic [IN_WIDTH-1:0]      src_data,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] write_address,
    output logic [RAM_WIDTH-1:0]     input_data,
    output logic                     busy,
    output logic                     done,
`ifdef DIVQ_REM_OUT_EN
    output logic                     ovf,
    output logic                     rem_we,
    output logic [RAM_WIDTH-1:0]     rem_data
`else
    output logic                     ovf
`endif
);

    // The datapath is one bit wider than the source so that the running
    // remainder and the shifted divisor never overflow during a step.
    localparam int DW     = IN_WIDTH + 1;
    localparam int STEP_W = $clog2(RAM_WIDTH);

    localparam logic [DW-1:0]            Q_EXT     = DW'(Q);
    localparam logic [DW-1:0]            SAT_LIMIT = Q_EXT << RAM_WIDTH;
    localparam logic [RAM_ADDR_BITS:0]   MAX_COUNT = {1'b1, {RAM_ADDR_BITS{1'b0}}};
    localparam logic [STEP_W-1:0]        TOP_STEP  = STEP_W'(RAM_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DIV   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [RAM_ADDR_BITS:0]   count_q, count_d;
    logic [DW-1:0]            rem_q, rem_d;
    logic [RAM_WIDTH-1:0]     quot_q, quot_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic                     sat_q, sat_d;
    logic                     ovf_q, ovf_d;

    logic [DW-1:0]            divisor_shift;
    logic [DW-1:0]            trial_diff;
    logic                     trial_ge;
    logic [DW-1:0]            src_ext;

    // State and datapath registers; reset aborts any run on the spot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            step_q  <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            step_q  <= step_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic plus one restoring-division step per DIV cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        step_d  = step_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;

        src_ext       = DW'(src_data);
        divisor_shift = Q_EXT << step_q;
        trial_ge      = (rem_q >= divisor_shift);
        trial_diff    = rem_q - divisor_shift;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = (count > MAX_COUNT) ? MAX_COUNT : count;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    sat_d   = 1'b0;
                    rem_d   = '0;
                    quot_d  = '0;
                    state_d = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rem_d  = src_ext;
                quot_d = '0;
                step_d = TOP_STEP;
                if (src_ext >= SAT_LIMIT) begin
                    sat_d = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    sat_d = 1'b0;
                end
                state_d = DIV;
            end
            DIV: begin
                if (trial_ge) begin
                    rem_d = trial_diff;
                end
                quot_d = {quot_q[RAM_WIDTH-2:0], trial_ge};
                if (step_q == '0) begin
                    state_d = WRITE;
                end else begin
                    step_d = step_q - 1'b1;
                end
            end
            WRITE: begin
                if ({1'b0, idx_q} == (count_q - 1'b1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode directly from registers, so they are glitch-free
    // and read as zero straight after reset.
    assign src_addr      = idx_q;
    assign write_enable  = (state_q == WRITE);
    assign write_address = idx_q;
    assign input_data    = sat_q ? {RAM_WIDTH{1'b1}} : quot_q;
    assign busy          = (state_q == FETCH) || (state_q == DIV) || (state_q == WRITE);
    assign done          = (state_q == DONE);
    assign ovf           = ovf_q;

`ifdef DIVQ_REM_OUT_EN
    // The final remainder is below Q, so its low RAM_WIDTH bits hold it whole.
    assign rem_we   = (state_q == WRITE);
    assign rem_data = sat_q ? '0 : rem_q[RAM_WIDTH-1:0];
`endif

endmodule
